data_memory_sized: RTL and testbench
====================================

# data_memory_sized

Parametrised, byte-addressed, big-endian data memory for the MEM stage of the pipelined MIPS core. Supports byte/halfword/word loads and stores with sign or zero extension, flags misaligned accesses instead of corrupting memory, and keeps the Debug Unit byte-read port. Adds a sequential clear engine, so the Debug Unit can zero the whole array between program runs without reprogramming the FPGA.

## Interface
Parameters:
- NB_DATA, 32, data bus width; a multiple of 8; LANES = NB_DATA/8.
- NB_ADDR, 7, byte-address width.
- MEMORY_DEPTH, 128, bytes of storage; equals 2**NB_ADDR and is a multiple of LANES.

Ports:
- i_clock  in  1  single clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  gates CPU read and write ports; low means no access and outputs hold.
- i_mem_write_flag  in  1  store request.
- i_mem_read_flag  in  1  load request.
- i_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- i_unsigned  in  1  loads: 1 zero-extends, 0 sign-extends.
- i_address  in  NB_ADDR  byte address of the MSB of the access.
- i_write_data  in  NB_DATA  store data, right-aligned.
- o_read_data  out  NB_DATA  registered, extended load result.
- o_read_valid  out  1  one-cycle pulse when o_read_data updates.
- o_misaligned  out  1  one-cycle pulse on a rejected access.
- i_read_enable  in  1  Debug Unit byte read.
- i_read_address  in  NB_ADDR  Debug Unit byte address.
- o_byte_data  out  8  registered debug byte.
- i_clear_req  in  1  starts the clear engine; sampled only in IDLE.
- o_busy  out  1  high while clearing.
- o_clear_done  out  1  one-cycle pulse when the clear completes.

## Operation
- Storage: MEMORY_DEPTH x 8-bit array, zero at power-up. Big-endian: address A holds the most significant byte, and A+1..A+n-1 hold the following bytes.
- Alignment rules:
  - A halfword requires address[0]=0.
  - A word (NB_DATA=32) requires address[1:0]=0.
  - Byte accesses are always legal.
  - i_size=11 is always illegal.
- Misaligned or illegal store: the array is not written.
- Misaligned or illegal load: o_read_data is loaded with 0 and o_read_valid pulses.
- Either case pulses o_misaligned in the cycle after the request.
- Stores (i_enable=1, legal):
  - Byte writes i_write_data[7:0].
  - Halfword writes [15:8] to A and [7:0] to A+1.
  - Word writes [31:24] to A through [7:0] to A+3.
- Loads (i_enable=1, legal):
  - Bytes are assembled MSB-first.
  - The result is extended to NB_DATA: bit 7 (byte) or bit 15 (halfword) is replicated when i_unsigned=0; zeros otherwise.
- Read and write in the same cycle at overlapping addresses: the load returns the old data (read-before-write).
- The debug port ignores i_enable. With i_read_enable=1, o_byte_data is loaded with the old byte at i_read_address.
- Clear FSM:
  - IDLE to CLEAR on i_clear_req=1.
  - In CLEAR, ptr counts 0 to MEMORY_DEPTH/LANES - 1. Each cycle zeroes bytes ptr*LANES .. ptr*LANES+LANES-1.
  - After the last group, CLEAR goes to DONE. DONE asserts o_clear_done for one cycle, then returns to IDLE.
- While the FSM is in CLEAR or DONE:
  - o_busy=1.
  - CPU reads and writes are dropped: no valid or misaligned pulse.
  - Debug reads still work.
  - i_clear_req is ignored.
- The clear engine runs regardless of i_enable.

## Timing
- Load latency is 1 cycle. A request sampled at edge N produces o_read_data, o_read_valid and o_misaligned after edge N.
- A store is visible to a load issued in the following cycle.
- o_read_data and o_byte_data hold their value between updates.
- Clear duration: MEMORY_DEPTH/LANES cycles in CLEAR plus 1 cycle in DONE (32+1 at the defaults). o_busy falls on the edge that ends DONE.
- Reset values: o_read_data=0, o_read_valid=0, o_misaligned=0, o_byte_data=0, o_busy=0, o_clear_done=0, FSM=IDLE, ptr=0.
- Reset does not clear array contents.
- Reset mid-clear: the FSM aborts to IDLE; already-zeroed groups stay zero and the rest keep their data; no o_clear_done pulse.

## Test plan
- Word store 0xDEADBEEF at address 8, then word load from 8: o_read_data=0xDEADBEEF. Debug reads of addresses 8..11 return 0xDE, 0xAD, 0xBE, 0xEF.
- Signed and unsigned byte loads at address 9 (0xAD): 0xFFFFFFAD and 0x000000AD. Halfword loads at 10 (0xBEEF): 0xFFFFBEEF and 0x0000BEEF.
- Word store to address 6, then halfword load at 5: o_misaligned pulses both times, memory at 6..9 is unchanged, and o_read_data=0 with o_read_valid=1.
- In the same cycle, word store 0x11223344 to address 0 and word load from 0 (prior value 0xCAFEF00D): o_read_data=0xCAFEF00D. The next load returns 0x11223344.
- Fill memory with 0xA5, pulse i_clear_req: o_busy is high for 33 cycles, o_clear_done pulses once, every debug read returns 0x00, and CPU accesses during busy produce no pulses.
- Assert i_reset after 10 clear cycles: outputs go to reset values immediately, addresses 0..39 read 0x00, and addresses 40..127 still read 0xA5.

Source files
------------

// File: rtl/data_memory_sized_if.sv
// CPU load/store, Debug Unit byte-read and clear-engine signals of the MEM-stage data memory.
// The bench drives through master; the memory sits on slave.
interface data_memory_sized_if #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 7
);
  logic               i_enable;
  logic               i_mem_write_flag;
  logic               i_mem_read_flag;
  logic [1:0]         i_size;
  logic               i_unsigned;
  logic [NB_ADDR-1:0] i_address;
  logic [NB_DATA-1:0] i_write_data;
  logic [NB_DATA-1:0] o_read_data;
  logic               o_read_valid;
  logic               o_misaligned;
  logic               i_read_enable;
  logic [NB_ADDR-1:0] i_read_address;
  logic [7:0]         o_byte_data;
  logic               i_clear_req;
  logic               o_busy;
  logic               o_clear_done;

  modport master (
    output i_enable, i_mem_write_flag, i_mem_read_flag, i_size, i_unsigned,
           i_address, i_write_data, i_read_enable, i_read_address, i_clear_req,
    input  o_read_data, o_read_valid, o_misaligned, o_byte_data, o_busy, o_clear_done
  );

  modport slave (
    input  i_enable, i_mem_write_flag, i_mem_read_flag, i_size, i_unsigned,
           i_address, i_write_data, i_read_enable, i_read_address, i_clear_req,
    output o_read_data, o_read_valid, o_misaligned, o_byte_data, o_busy, o_clear_done
  );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressed big-endian data memory with sized/extended loads, misalignment flagging,
// a Debug Unit byte port and a sequential clear engine that zeroes one word-group per cycle.
module data_memory_sized #(
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned NB_ADDR      = 7,
  parameter int unsigned MEMORY_DEPTH = 128
) (
  input logic                 i_clock,
  input logic                 i_reset,
  data_memory_sized_if.slave  bus
);
  localparam int unsigned LANES  = NB_DATA / 8;
  localparam int unsigned GROUPS = MEMORY_DEPTH / LANES;
  localparam int unsigned PTR_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  logic [7:0]         mem_q [MEMORY_DEPTH];
  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               clear_we_c, last_c;
  logic [NB_DATA-1:0] rdata_q;
  logic               valid_q, mis_q;
  logic [7:0]         byte_q;

  logic [2:0]         nbytes_c;
  logic               legal_c, cpu_go_c, ld_req_c, st_req_c;
  logic [NB_DATA-1:0] rd_raw_c, ld_ext_c, wr_al_c;

  // Access decode: byte count, alignment and legality
  always_comb begin
    case (bus.i_size)
      2'b00:   nbytes_c = 3'd1;
      2'b01:   nbytes_c = 3'd2;
      2'b10:   nbytes_c = 3'd4;
      default: nbytes_c = 3'd0;
    endcase
    legal_c  = (nbytes_c != 3'd0) && (32'(nbytes_c) <= LANES) &&
               ((bus.i_address & NB_ADDR'(nbytes_c - 3'd1)) == '0);
    cpu_go_c = bus.i_enable && (state_q == IDLE);
    ld_req_c = cpu_go_c && bus.i_mem_read_flag;
    st_req_c = cpu_go_c && bus.i_mem_write_flag;
  end

  // Load assembly MSB-first, then sign/zero extension
  always_comb begin
    rd_raw_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (l < int'(nbytes_c))
        rd_raw_c = (rd_raw_c << 8) | NB_DATA'(mem_q[bus.i_address + NB_ADDR'(l)]);
    end
    case (bus.i_size)
      2'b00:   ld_ext_c = bus.i_unsigned ? NB_DATA'(rd_raw_c[7:0])
                                         : {{(NB_DATA-8){rd_raw_c[7]}}, rd_raw_c[7:0]};
      2'b01:   ld_ext_c = bus.i_unsigned ? NB_DATA'(rd_raw_c[15:0])
                                         : {{(NB_DATA-16){rd_raw_c[15]}}, rd_raw_c[15:0]};
      default: ld_ext_c = rd_raw_c;
    endcase
    wr_al_c = bus.i_write_data << ((LANES - 32'(nbytes_c)) * 8);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign last_c = (ptr_q == PTR_W'(GROUPS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_clear_req) state_d = CLEAR;
      CLEAR:   if (last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Busy/done are registered copies of the upcoming state so they align with it
  always_comb begin
    ptr_d      = ptr_q;
    clear_we_c = 1'b0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    if (state_q == CLEAR) begin
      clear_we_c = 1'b1;
      ptr_d      = last_c ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      byte_q  <= '0;
    end else begin
      valid_q <= ld_req_c;
      mis_q   <= (ld_req_c || st_req_c) && !legal_c;
      if (ld_req_c) rdata_q <= legal_c ? ld_ext_c : '0;
      if (bus.i_read_enable) byte_q <= mem_q[bus.i_read_address];
    end
  end

  // Storage has no reset so a reset cannot wipe program data
  always_ff @(posedge i_clock) begin
    if (clear_we_c) begin
      for (int l = 0; l < int'(LANES); l++)
        mem_q[NB_ADDR'(int'(ptr_q) * int'(LANES) + l)] <= 8'h00;
    end else if (st_req_c && legal_c) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (l < int'(nbytes_c))
          mem_q[bus.i_address + NB_ADDR'(l)] <= wr_al_c[NB_DATA-1-8*l -: 8];
      end
    end
  end

  assign bus.o_read_data  = rdata_q;
  assign bus.o_read_valid = valid_q;
  assign bus.o_misaligned = mis_q;
  assign bus.o_byte_data  = byte_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_clear_done = done_q;
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: sized loads/stores, misalignment, read-before-write,
// debug byte port, clear engine and reset during a clear.
module tb_data_memory_sized;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  data_memory_sized_if #(.NB_DATA(32), .NB_ADDR(7)) bus ();

  data_memory_sized #(.NB_DATA(32), .NB_ADDR(7), .MEMORY_DEPTH(128)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.i_enable = 1'b0; bus.i_mem_write_flag = 1'b0; bus.i_mem_read_flag = 1'b0;
    bus.i_size = 2'b00; bus.i_unsigned = 1'b0; bus.i_address = '0; bus.i_write_data = '0;
    bus.i_read_enable = 1'b0; bus.i_read_address = '0; bus.i_clear_req = 1'b0;
  endtask

  task automatic drive(input logic en, input logic wr, input logic rd, input logic [1:0] sz,
                       input logic uns, input logic [6:0] addr, input logic [31:0] wd);
    bus.i_enable = en; bus.i_mem_write_flag = wr; bus.i_mem_read_flag = rd;
    bus.i_size = sz; bus.i_unsigned = uns; bus.i_address = addr; bus.i_write_data = wd;
  endtask

  task automatic store(input logic [1:0] sz, input logic [6:0] addr, input logic [31:0] wd);
    drive(1'b1, 1'b1, 1'b0, sz, 1'b0, addr, wd);
    tick();
    idle_bus();
  endtask

  task automatic load(input logic [1:0] sz, input logic uns, input logic [6:0] addr);
    drive(1'b1, 1'b0, 1'b1, sz, uns, addr, 32'h0);
    tick();
    idle_bus();
  endtask

  task automatic dbg(input logic [6:0] addr);
    bus.i_read_enable = 1'b1; bus.i_read_address = addr;
    tick();
    bus.i_read_enable = 1'b0;
  endtask

  initial begin
    int busy_cycles, done_pulses, stray, bad;
    logic [7:0] dexp [4];

    idle_bus();
    rst = 1'b1;
    tick(); tick();
    check("reset read_data", bus.o_read_data, 32'h0);
    check("reset read_valid", 32'(bus.o_read_valid), 32'h0);
    check("reset misaligned", 32'(bus.o_misaligned), 32'h0);
    check("reset byte_data", 32'(bus.o_byte_data), 32'h0);
    check("reset busy", 32'(bus.o_busy), 32'h0);
    check("reset clear_done", 32'(bus.o_clear_done), 32'h0);
    rst = 1'b0;
    tick();

    // Word store / load and debug byte readback
    store(2'b10, 7'd4, 32'h01020304);
    store(2'b10, 7'd8, 32'hDEADBEEF);
    check("aligned store no misaligned", 32'(bus.o_misaligned), 32'h0);
    load(2'b10, 1'b0, 7'd8);
    check("word load 8", bus.o_read_data, 32'hDEADBEEF);
    check("word load valid", 32'(bus.o_read_valid), 32'h1);
    tick();
    check("valid one cycle", 32'(bus.o_read_valid), 32'h0);
    check("read_data holds", bus.o_read_data, 32'hDEADBEEF);
    dexp[0] = 8'hDE; dexp[1] = 8'hAD; dexp[2] = 8'hBE; dexp[3] = 8'hEF;
    for (int i = 0; i < 4; i++) begin
      dbg(7'(8 + i));
      check($sformatf("debug byte %0d", 8 + i), 32'(bus.o_byte_data), 32'(dexp[i]));
    end

    // Sized loads with sign / zero extension
    load(2'b00, 1'b0, 7'd9);
    check("byte signed 9", bus.o_read_data, 32'hFFFFFFAD);
    load(2'b00, 1'b1, 7'd9);
    check("byte unsigned 9", bus.o_read_data, 32'h000000AD);
    load(2'b01, 1'b0, 7'd10);
    check("half signed 10", bus.o_read_data, 32'hFFFFBEEF);
    load(2'b01, 1'b1, 7'd10);
    check("half unsigned 10", bus.o_read_data, 32'h0000BEEF);

    // Misaligned and illegal accesses
    store(2'b10, 7'd6, 32'hFFFFFFFF);
    check("misaligned word store", 32'(bus.o_misaligned), 32'h1);
    check("misaligned store no valid", 32'(bus.o_read_valid), 32'h0);
    load(2'b01, 1'b0, 7'd5);
    check("misaligned half load flag", 32'(bus.o_misaligned), 32'h1);
    check("misaligned half load valid", 32'(bus.o_read_valid), 32'h1);
    check("misaligned half load data", bus.o_read_data, 32'h0);
    dexp[0] = 8'h03; dexp[1] = 8'h04; dexp[2] = 8'hDE; dexp[3] = 8'hAD;
    for (int i = 0; i < 4; i++) begin
      dbg(7'(6 + i));
      check($sformatf("unchanged byte %0d", 6 + i), 32'(bus.o_byte_data), 32'(dexp[i]));
    end
    store(2'b11, 7'd0, 32'h55555555);
    check("illegal size store", 32'(bus.o_misaligned), 32'h1);
    load(2'b00, 1'b1, 7'd9);
    load(2'b11, 1'b0, 7'd0);
    check("illegal size load flag", 32'(bus.o_misaligned), 32'h1);
    check("illegal size load data", bus.o_read_data, 32'h0);

    // Read-before-write in the same cycle
    store(2'b10, 7'd0, 32'hCAFEF00D);
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 7'd0, 32'h11223344);
    tick();
    idle_bus();
    check("same-cycle load old data", bus.o_read_data, 32'hCAFEF00D);
    load(2'b10, 1'b0, 7'd0);
    check("next load new data", bus.o_read_data, 32'h11223344);

    // Disabled port: no pulse, data holds
    drive(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 7'd8, 32'h0);
    tick();
    idle_bus();
    check("disabled no valid", 32'(bus.o_read_valid), 32'h0);
    check("disabled data holds", bus.o_read_data, 32'h11223344);

    // Full clear with CPU traffic while busy
    for (int a = 0; a < 128; a += 4) store(2'b10, 7'(a), 32'hA5A5A5A5);
    bus.i_clear_req = 1'b1;
    tick();
    bus.i_clear_req = 1'b0;
    busy_cycles = 0; done_pulses = 0; stray = 0;
    while (bus.o_busy && busy_cycles < 100) begin
      busy_cycles++;
      done_pulses += int'(bus.o_clear_done);
      stray += int'(bus.o_read_valid) + int'(bus.o_misaligned);
      if (busy_cycles % 2 == 0) drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 7'd1, 32'h0);
      else                      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 7'd0, 32'h12345678);
      tick();
    end
    stray += int'(bus.o_read_valid) + int'(bus.o_misaligned);
    idle_bus();
    check("busy cycles", 32'(busy_cycles), 32'd33);
    check("clear_done pulses", 32'(done_pulses), 32'd1);
    check("no cpu pulses while busy", 32'(stray), 32'd0);
    check("clear_done after idle", 32'(bus.o_clear_done), 32'h0);
    bad = 0;
    for (int a = 0; a < 128; a++) begin
      dbg(7'(a));
      if (bus.o_byte_data !== 8'h00) bad++;
    end
    check("nonzero bytes after clear", 32'(bad), 32'd0);

    // Reset ten cycles into a clear
    for (int a = 0; a < 128; a += 4) store(2'b10, 7'(a), 32'hA5A5A5A5);
    load(2'b10, 1'b0, 7'd0);
    bus.i_clear_req = 1'b1;
    tick();
    bus.i_clear_req = 1'b0;
    repeat (10) tick();
    check("busy before abort", 32'(bus.o_busy), 32'h1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(bus.o_busy), 32'h0);
    check("abort clear_done", 32'(bus.o_clear_done), 32'h0);
    check("abort read_data", bus.o_read_data, 32'h0);
    check("abort byte_data", 32'(bus.o_byte_data), 32'h0);
    tick();
    rst = 1'b0;
    bad = 0;
    for (int a = 0; a < 128; a++) begin
      dbg(7'(a));
      if (bus.o_byte_data !== ((a < 40) ? 8'h00 : 8'hA5)) bad++;
      if (bus.o_clear_done !== 1'b0 || bus.o_busy !== 1'b0) bad++;
    end
    check("partial clear contents", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
